// File: rtl/combinational_logic.sv
// combinational_logic: table-driven 3-input Boolean cell with a registered copy and a saturating rising-edge counter
module combinational_logic #(
    parameter logic [7:0] TRUTH_TABLE = 8'b1110_1000,
    parameter int         CNT_W       = 8
) (
    input  logic             A,
    input  logic             B,
    input  logic             C,
    output logic             F,
    input  logic             clk,
    input  logic             rst,
    output logic             F_q,
    output logic [CNT_W-1:0] rise_cnt
);
    assign F = TRUTH_TABLE[{A, B, C}];
    always_ff @(posedge clk) begin
        if (rst) begin
            F_q      <= 1'b0;
            rise_cnt <= '0;
        end else begin
            F_q <= F;
            if (F && !F_q && rise_cnt != '1) rise_cnt <= rise_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_combinational_logic.sv
// tb_combinational_logic: randomized and directed checks of the truth-table cell against a behavioural model
module tb_combinational_logic;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic A = 1'b0, B = 1'b0, C = 1'b0;
    logic F, F_q, F_x, F_s, Fq_x, Fq_s;
    logic [7:0] rise_cnt, cnt_x;
    logic [1:0] cnt_s;

    int passed = 0;
    int total  = 0;

    int mq = 0, mcnt = 0, mcnt_s = 0;
    bit en = 0;

    always #5 clk = ~clk;

    combinational_logic dut (
        .A(A), .B(B), .C(C), .F(F), .clk(clk), .rst(rst), .F_q(F_q), .rise_cnt(rise_cnt)
    );
    combinational_logic #(.TRUTH_TABLE(8'b1001_0110)) u_xor (
        .A(A), .B(B), .C(C), .F(F_x), .clk(clk), .rst(rst), .F_q(Fq_x), .rise_cnt(cnt_x)
    );
    combinational_logic #(.CNT_W(2)) u_sat (
        .A(A), .B(B), .C(C), .F(F_s), .clk(clk), .rst(rst), .F_q(Fq_s), .rise_cnt(cnt_s)
    );

    function automatic int maj();
        return (int'(A) + int'(B) + int'(C)) >= 2 ? 1 : 0;
    endfunction

    function automatic int par();
        return (int'(A) + int'(B) + int'(C)) % 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mq = 0;
            mcnt = 0;
            mcnt_s = 0;
            en = 1;
        end else begin
            if (maj() == 1 && mq == 0) begin
                mcnt   = mcnt < 255 ? mcnt + 1 : 255;
                mcnt_s = mcnt_s < 3 ? mcnt_s + 1 : 3;
            end
            mq = maj();
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("F", 32'(F), 32'(maj()));
            chk("F_xor", 32'(F_x), 32'(par()));
            chk("F_sat", 32'(F_s), 32'(maj()));
            chk("F_q", 32'(F_q), 32'(mq));
            chk("F_q_sat", 32'(Fq_s), 32'(mq));
            chk("rise_cnt", 32'(rise_cnt), 32'(mcnt));
            chk("rise_cnt_sat", 32'(cnt_s), 32'(mcnt_s));
        end
    end

    initial begin
        logic [7:0] maj_seq;
        logic [2:0] v;
        maj_seq = 8'b1110_1000;
        step();
        step();
        {A, B, C} = 3'b010;
        #5;
        chk("lit_010", 32'(F), 32'd0);
        step();
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {A, B, C} = v;
            #2;
            chk("lit_maj_sweep", 32'(F), 32'(maj_seq[i]));
            chk("lit_xor_sweep", 32'(F_x), 32'(v[2] ^ v[1] ^ v[0]));
            #3;
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        {A, B, C} = 3'b011;
        step();
        chk("lit_fq_lag", 32'(F_q), 32'd1);
        {A, B, C} = 3'b000;
        step();
        chk("lit_fq_lag0", 32'(F_q), 32'd0);
        {A, B, C} = 3'b011;
        step();
        {A, B, C} = 3'b000;
        step();
        {A, B, C} = 3'b011;
        step();
        chk("lit_rise3", 32'(rise_cnt), 32'd3);
        for (int i = 0; i < 2; i++) begin
            {A, B, C} = 3'b000;
            step();
            {A, B, C} = 3'b011;
            step();
        end
        chk("lit_rise5", 32'(rise_cnt), 32'd5);
        chk("lit_sat3", 32'(cnt_s), 32'd3);
        {A, B, C} = 3'b111;
        step();
        rst = 1'b1;
        step();
        chk("lit_rst_fq", 32'(F_q), 32'd0);
        chk("lit_rst_cnt", 32'(rise_cnt), 32'd0);
        chk("lit_rst_f", 32'(F), 32'd1);
        rst = 1'b0;
        step();
        chk("lit_rel_fq", 32'(F_q), 32'd1);
        chk("lit_rel_cnt", 32'(rise_cnt), 32'd1);
        for (int i = 0; i < 300; i++) begin
            {A, B, C} = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 29) == 0);
            step();
        end
        rst = 1'b0;
        step();
        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
